// File: rtl/tone_voice.sv
// Monophonic voice: phase accumulator, attack/sustain/release envelope and PWM level gating.
// A zero frequency word on trig is a rest: it releases a sounding note and is ignored when idle.
module tone_voice #(
    parameter int ACC_W        = 24,
    parameter int ENV_STEP_DIV = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    input  logic [15:0] freq_in,
    input  logic        gate,
    output logic        wave_out,
    output logic [7:0]  saw_out,
    output logic [7:0]  level_out,
    output logic        busy
);
    localparam int               PRE_W    = (ENV_STEP_DIV > 1) ? $clog2(ENV_STEP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(ENV_STEP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t           r_state;
    logic [15:0]      r_freq;
    logic [ACC_W-1:0] r_phase;
    logic [7:0]       r_env;
    logic [7:0]       r_pwm;
    logic [PRE_W-1:0] r_pre;
    logic             r_wave;

    logic w_step;
    logic w_note;
    logic w_rest;
    logic w_env_on;

    assign w_step   = (r_pre == PRE_LAST);
    assign w_note   = trig && (freq_in != 16'd0);
    assign w_rest   = trig && (freq_in == 16'd0) && (r_state != IDLE);
    assign w_env_on = (r_pwm < r_env);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_freq  <= '0;
            r_phase <= '0;
            r_env   <= '0;
            r_pwm   <= '0;
            r_pre   <= '0;
            r_wave  <= 1'b0;
        end else begin
            r_pwm  <= r_pwm + 8'd1;
            r_wave <= r_phase[ACC_W-1] & w_env_on & (r_state != IDLE);
            r_pre  <= w_step ? '0 : r_pre + PRE_W'(1);
            // NOTE: all state uses non-blocking assignments; a later assignment in this block
            // overrides the default accumulate, which is how phase is forced to 0 on entering IDLE.
            if (r_state != IDLE)
                r_phase <= r_phase + ACC_W'(r_freq);

            if (w_note) begin
                r_freq  <= freq_in;
                r_phase <= '0;
                r_pre   <= '0;
                r_state <= ATTACK;
            end else if (w_rest) begin
                r_pre   <= '0;
                r_state <= RELEASE;
            end else begin
                case (r_state)
                    ATTACK: begin
                        if (!gate)
                            r_state <= RELEASE;
                        else if (r_env == 8'hFF)
                            r_state <= SUSTAIN;
                        else if (w_step) begin
                            r_env <= r_env + 8'd1;
                            if (r_env == 8'hFE)
                                r_state <= SUSTAIN;
                        end
                    end
                    SUSTAIN: begin
                        if (!gate)
                            r_state <= RELEASE;
                    end
                    RELEASE: begin
                        // Gate is deliberately ignored here: only a new trig restarts the note.
                        if (r_env == 8'd0) begin
                            r_state <= IDLE;
                            r_phase <= '0;
                        end else if (w_step) begin
                            r_env <= r_env - 8'd1;
                            if (r_env == 8'd1) begin
                                r_state <= IDLE;
                                r_phase <= '0;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign wave_out  = r_wave;
    assign saw_out   = r_phase[ACC_W-1 -: 8];
    assign level_out = r_env;
    assign busy      = (r_state != IDLE);

endmodule
